spu32_cpu_alu_xl: RTL
=====================

Name: spu32_cpu_alu_xl

Overview:
Parametrised next-generation execute ALU for the spu32 core. XLEN-wide and multi-cycle aware.
- Integer ops plus the full M extension, including an iterative divider (DIV/DIVU/REM/REMU).
- Selectable single-cycle or iterative shifter.
- Sits between decode/register read and writeback. The CPU FSM strobes I_en, then waits on O_busy.

Parameters:
XLEN, 32, datapath width; even, >=8.
SHIFT_ITER, 0, 0 = single-cycle barrel shifter; 1 = iterative shifter.
SHIFT_STEP, 4, bits shifted per cycle when SHIFT_ITER=1; power of two, 1..XLEN/2.
MUL_STAGES, 2, registered multiplier pipeline stages; 1..4.

Ports:
I_clk  in  1  clock; all state on rising edge.
I_reset  in  1  synchronous, active-high reset.
I_en  in  1  start strobe; sampled only while O_busy=0.
I_aluop  in  5  operation code (ALUOP_* in shared package).
I_dataS1  in  XLEN  operand 1.
I_dataS2  in  XLEN  operand 2; shift amount = low log2(XLEN) bits.
O_data  out  XLEN  registered result.
O_busy  out  1  registered; high while a multi-cycle op runs.
O_done  out  1  registered one-cycle pulse when O_data is updated.
O_loadstore_adr  out  XLEN  combinational I_dataS1+I_dataS2 (mod 2^XLEN).
O_lt  out  1  combinational signed S1<S2.
O_ltu  out  1  combinational unsigned S1<S2.
O_eq  out  1  combinational S1==S2.

Behaviour:
- Reset: O_data=0, O_busy=0, O_done=0, FSM=IDLE, iteration counters=0.
- Reset mid-operation aborts the op; the next cycle is IDLE with O_data=0.
- FSM states: IDLE, SHIFT, MUL, DIV, FIN.
- Operands and opcode are latched on start. Input changes while busy are ignored. I_en while O_busy=1 is ignored; the op is not queued.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, and shifts when SHIFT_ITER=0):
  - I_en in cycle N gives O_data and O_done=1 at N+1.
  - O_busy stays 0.
- SLT/SLTU: result is zero-extended 1 bit. Signed compare = borrow of (XLEN+1)-bit subtract XOR (S1^S2)[MSB].
- Unknown opcodes behave as ADD.
- Iterative shift (SHIFT_ITER=1):
  - shamt=0 completes as single-cycle.
  - Otherwise SHIFT state runs ceil(shamt/SHIFT_STEP) cycles; the last step shifts only the remainder.
  - O_busy is high from N+1 through the last step. O_data/O_done are valid the cycle O_busy falls (FIN).
  - SRA fills with the latched sign bit.
- MUL/MULH/MULHSU/MULHU:
  - 2*XLEN-bit product; MUL returns the low half, the others the high half with the proper signedness.
  - O_busy is high for MUL_STAGES cycles, then FIN.
- DIV/DIVU/REM/REMU: radix-2 restoring divider on magnitudes, XLEN cycles in DIV, then FIN with sign fix-up. Total latency XLEN+2 cycles.
  - Quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - Divide by zero: quotient = all ones, remainder = dividend. Completes single-cycle, no busy.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0. Completes single-cycle.
- O_done asserts only in the cycle O_data updates. A back-to-back I_en in the same cycle as O_done/busy-fall is accepted.

Decomposition:
- Shared package (extends aludefs): 5-bit ALUOP_* encodings:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
  - MUL=10, MULH=11, MULHSU=12, MULHU=13.
  - DIV=16, DIVU=17, REM=18, REMU=19.
- The package also holds the FSM state encodings and an is_multicycle helper.
- One sub-module: spu32_cpu_divider (XLEN parameter; start/busy/done handshake; returns quotient and remainder magnitudes). Sign handling stays in the ALU.

Test Plan:
- Reset then ADD 0xFFFFFFFF+1 -> O_data=0x00000000, O_done=1 at N+1, O_busy=0. SLT 0x80000000,1 -> 1; SLTU same operands -> 0.
- SHIFT_ITER=1, STEP=4: SRA 0x80000000 by 9 -> O_busy high 3 cycles, then O_data=0xFFC00000. SLL by 0 -> single-cycle, O_data=S1.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHU same -> 0xFFFFFFFE. MUL_STAGES=2 gives 2 busy cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. Latency 34 cycles. DIVU 100/7 -> 14.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000; REM -> 0. All single-cycle, O_busy never set.
- I_reset at cycle 10 of a DIV -> O_busy=0, O_data=0 next cycle. New ADD issued right after runs normally. I_en pulses during busy are ignored.

Source files
------------

// File: rtl/spu32_cpu_alu_xl_pkg.sv
// Shared ALU definitions for the spu32 execute stage: opcode encodings,
// FSM state encoding and operation-class helpers.
package spu32_cpu_alu_xl_pkg;

    localparam logic [4:0] ALUOP_ADD    = 5'd0;
    localparam logic [4:0] ALUOP_SUB    = 5'd1;
    localparam logic [4:0] ALUOP_AND    = 5'd2;
    localparam logic [4:0] ALUOP_OR     = 5'd3;
    localparam logic [4:0] ALUOP_XOR    = 5'd4;
    localparam logic [4:0] ALUOP_SLT    = 5'd5;
    localparam logic [4:0] ALUOP_SLTU   = 5'd6;
    localparam logic [4:0] ALUOP_SLL    = 5'd7;
    localparam logic [4:0] ALUOP_SRL    = 5'd8;
    localparam logic [4:0] ALUOP_SRA    = 5'd9;
    localparam logic [4:0] ALUOP_MUL    = 5'd10;
    localparam logic [4:0] ALUOP_MULH   = 5'd11;
    localparam logic [4:0] ALUOP_MULHSU = 5'd12;
    localparam logic [4:0] ALUOP_MULHU  = 5'd13;
    localparam logic [4:0] ALUOP_DIV    = 5'd16;
    localparam logic [4:0] ALUOP_DIVU   = 5'd17;
    localparam logic [4:0] ALUOP_REM    = 5'd18;
    localparam logic [4:0] ALUOP_REMU   = 5'd19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } alu_state_e;

    function automatic logic is_mul_op(input logic [4:0] op);
        return op inside {ALUOP_MUL, ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU};
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
    endfunction

    function automatic logic is_shift_op(input logic [4:0] op);
        return op inside {ALUOP_SLL, ALUOP_SRL, ALUOP_SRA};
    endfunction

    // Shifts by zero never need the iterative path, even when it is enabled.
    function automatic logic is_multicycle(input logic [4:0] op,
                                           input logic       shiftIter,
                                           input logic       shamtNonZero);
        return is_mul_op(op) || is_div_op(op) ||
               (shiftIter && shamtNonZero && is_shift_op(op));
    endfunction

endpackage

// File: rtl/spu32_cpu_alu_xl_divider.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per
// cycle, XLEN cycles per division, done pulses once results are final.
module spu32_cpu_divider #(
    parameter int XLEN = 32
) (
    input  logic            I_clk,
    input  logic            I_reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CW = $clog2(XLEN);

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN:0]   partial;
    logic [XLEN:0]   trial;

    // quot_q starts as the dividend; its MSB feeds the partial remainder
    // while quotient bits shift in from the bottom.
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        partial   = {rem_q, quot_q[XLEN-1]};
        trial     = partial - {1'b0, divisor_q};
        if (busy_q) begin
            if (!trial[XLEN]) begin
                rem_d  = trial[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d  = partial[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end
        end else if (start_i) begin
            busy_d    = 1'b1;
            cnt_d     = '0;
            rem_d     = '0;
            quot_d    = dividend_i;
            divisor_d = divisor_i;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/spu32_cpu_alu_xl.sv
// spu32 execute ALU: single-cycle integer ops plus multi-cycle shift,
// multiply and divide, with a start/busy/done handshake to the CPU FSM.
module spu32_cpu_alu_xl
    import spu32_cpu_alu_xl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_ITER = 0,
    parameter int SHIFT_STEP = 4,
    parameter int MUL_STAGES = 2
) (
    input  logic            I_clk,
    input  logic            I_reset,
    input  logic            I_en,
    input  logic [4:0]      I_aluop,
    input  logic [XLEN-1:0] I_dataS1,
    input  logic [XLEN-1:0] I_dataS2,
    output logic [XLEN-1:0] O_data,
    output logic            O_busy,
    output logic            O_done,
    output logic [XLEN-1:0] O_loadstore_adr,
    output logic            O_lt,
    output logic            O_ltu,
    output logic            O_eq
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    alu_state_e      state_q, state_d;
    logic [4:0]      aluop_q, aluop_d;
    logic [XLEN-1:0] shiftVal_q, shiftVal_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            negQ_q, negQ_d;
    logic            negR_q, negR_d;

    logic [XLEN:0]     cmpDiff;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   singleResult;
    logic              accept;
    logic [CW-1:0]     stepAmt;
    logic [XLEN-1:0]   shiftStepVal;
    logic              mulASigned, mulBSigned, mulLoad;
    logic [2*XLEN-1:0] mulA, mulB, mulProd;
    logic [2*XLEN-1:0] mulPipe_q [MUL_STAGES];
    logic [XLEN-1:0]   mulResult;
    logic              divSigned, divZero, divOvf, divStart;
    logic [XLEN-1:0]   absS1, absS2;
    logic              divBusy, divDone;
    logic [XLEN-1:0]   divQuot, divRem, divResult;

    // The (XLEN+1)-bit subtract gives the unsigned borrow; flipping it when
    // operand signs differ yields the signed comparison.
    assign cmpDiff         = {1'b0, I_dataS1} - {1'b0, I_dataS2};
    assign O_ltu           = cmpDiff[XLEN];
    assign O_lt            = cmpDiff[XLEN] ^ (I_dataS1[XLEN-1] ^ I_dataS2[XLEN-1]);
    assign O_eq            = (cmpDiff[XLEN-1:0] == '0);
    assign O_loadstore_adr = I_dataS1 + I_dataS2;
    assign shamt           = I_dataS2[SHW-1:0];
    assign accept          = I_en && !busy_q;

    always_comb begin
        singleResult = I_dataS1 + I_dataS2;
        case (I_aluop)
            ALUOP_SUB:  singleResult = cmpDiff[XLEN-1:0];
            ALUOP_AND:  singleResult = I_dataS1 & I_dataS2;
            ALUOP_OR:   singleResult = I_dataS1 | I_dataS2;
            ALUOP_XOR:  singleResult = I_dataS1 ^ I_dataS2;
            ALUOP_SLT:  singleResult = {{(XLEN-1){1'b0}}, O_lt};
            ALUOP_SLTU: singleResult = {{(XLEN-1){1'b0}}, O_ltu};
            ALUOP_SLL:  singleResult = I_dataS1 << shamt;
            ALUOP_SRL:  singleResult = I_dataS1 >> shamt;
            ALUOP_SRA:  singleResult = $signed(I_dataS1) >>> shamt;
            default:    singleResult = I_dataS1 + I_dataS2;
        endcase
    end

    // Each iterative step shifts by SHIFT_STEP, or just the remainder on the
    // last step; SRA keeps replicating the latched sign bit.
    always_comb begin
        stepAmt = (cnt_q < CW'(SHIFT_STEP)) ? cnt_q : CW'(SHIFT_STEP);
        case (aluop_q)
            ALUOP_SLL: shiftStepVal = shiftVal_q << stepAmt;
            ALUOP_SRL: shiftStepVal = shiftVal_q >> stepAmt;
            default:   shiftStepVal = $signed(shiftVal_q) >>> stepAmt;
        endcase
    end

    always_comb begin
        mulASigned = (I_aluop == ALUOP_MULH) || (I_aluop == ALUOP_MULHSU);
        mulBSigned = (I_aluop == ALUOP_MULH);
        mulA       = {{XLEN{mulASigned & I_dataS1[XLEN-1]}}, I_dataS1};
        mulB       = {{XLEN{mulBSigned & I_dataS2[XLEN-1]}}, I_dataS2};
        mulProd    = mulA * mulB;
        mulLoad    = accept && is_mul_op(I_aluop);
        mulResult  = (aluop_q == ALUOP_MUL) ? mulPipe_q[MUL_STAGES-1][XLEN-1:0]
                                            : mulPipe_q[MUL_STAGES-1][2*XLEN-1:XLEN];
    end

    always_ff @(posedge I_clk) begin
        if (mulLoad) begin
            mulPipe_q[0] <= mulProd;
        end
        for (int i = 1; i < MUL_STAGES; i++) begin
            mulPipe_q[i] <= mulPipe_q[i-1];
        end
    end

    always_comb begin
        divSigned = (I_aluop == ALUOP_DIV) || (I_aluop == ALUOP_REM);
        divZero   = (I_dataS2 == '0);
        divOvf    = divSigned && (I_dataS1 == {1'b1, {(XLEN-1){1'b0}}}) && (I_dataS2 == '1);
        absS1     = (divSigned && I_dataS1[XLEN-1]) ? -I_dataS1 : I_dataS1;
        absS2     = (divSigned && I_dataS2[XLEN-1]) ? -I_dataS2 : I_dataS2;
        if ((aluop_q == ALUOP_REM) || (aluop_q == ALUOP_REMU)) begin
            divResult = negR_q ? -divRem : divRem;
        end else begin
            divResult = negQ_q ? -divQuot : divQuot;
        end
    end

    spu32_cpu_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .I_clk      (I_clk),
        .I_reset    (I_reset),
        .start_i    (divStart),
        .dividend_i (absS1),
        .divisor_i  (absS2),
        .busy_o     (divBusy),
        .done_o     (divDone),
        .quotient_o (divQuot),
        .remainder_o(divRem)
    );

    // FIN is the result-presenting cycle and accepts a new op exactly like IDLE.
    always_comb begin
        state_d    = state_q;
        aluop_d    = aluop_q;
        shiftVal_d = shiftVal_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        done_d     = 1'b0;
        negQ_d     = negQ_q;
        negR_d     = negR_q;
        divStart   = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                shiftVal_d = shiftStepVal;
                cnt_d      = cnt_q - stepAmt;
                if (cnt_q == stepAmt) begin
                    data_d  = shiftStepVal;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_MUL: begin
                if (cnt_q == CW'(MUL_STAGES-1)) begin
                    data_d  = mulResult;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DIV: begin
                if (divDone) begin
                    data_d  = divResult;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (is_div_op(I_aluop) && (divZero || divOvf)) begin
                        if ((I_aluop == ALUOP_REM) || (I_aluop == ALUOP_REMU)) begin
                            data_d = divZero ? I_dataS1 : '0;
                        end else begin
                            data_d = divZero ? '1 : I_dataS1;
                        end
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else if (is_multicycle(I_aluop, SHIFT_ITER != 0, shamt != '0)) begin
                        aluop_d = I_aluop;
                        if (is_div_op(I_aluop)) begin
                            divStart = !divBusy;
                            negQ_d   = divSigned && (I_dataS1[XLEN-1] ^ I_dataS2[XLEN-1]);
                            negR_d   = divSigned && I_dataS1[XLEN-1];
                            state_d  = ST_DIV;
                        end else if (is_mul_op(I_aluop)) begin
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end else begin
                            shiftVal_d = I_dataS1;
                            cnt_d      = {1'b0, shamt};
                            state_d    = ST_SHIFT;
                        end
                    end else begin
                        data_d  = singleResult;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
        endcase
        busy_d = (state_d == ST_SHIFT) || (state_d == ST_MUL) || (state_d == ST_DIV);
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q    <= ST_IDLE;
            aluop_q    <= ALUOP_ADD;
            shiftVal_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            negQ_q     <= 1'b0;
            negR_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            aluop_q    <= aluop_d;
            shiftVal_q <= shiftVal_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            negQ_q     <= negQ_d;
            negR_q     <= negR_d;
        end
    end

    assign O_data = data_q;
    assign O_busy = busy_q;
    assign O_done = done_q;

endmodule
